// File: rtl/pipe_stage_reg_if.sv
// Bundle of the producer/consumer lanes, stall/flush controls and monitor outputs of
// pipe_stage_reg. The master side drives the stage inputs; the slave side is the register itself.
interface pipe_stage_reg_if #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 16
);
  logic [LANES-1:0]          in_valid;
  logic [LANES*DATA_W-1:0]   in_data;
  logic [LANES-1:0]          kill_mask;
  logic                      stall_prev;
  logic                      stall_next;
  logic                      flush;
  logic [LANES-1:0]          out_valid;
  logic [LANES*DATA_W-1:0]   out_data;
  logic [$clog2(LANES+1)-1:0] out_count;
  logic [CNT_W-1:0]          bubble_cnt;

  modport master (
    output in_valid, in_data, kill_mask, stall_prev, stall_next, flush,
    input  out_valid, out_data, out_count, bubble_cnt
  );

  modport slave (
    input  in_valid, in_data, kill_mask, stall_prev, stall_next, flush,
    output out_valid, out_data, out_count, bubble_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Multi-lane pipeline register: DEPTH slices of LANES valid/payload pairs with per-lane kill,
// flush/stall control and a saturating count of bubbles inserted at the first slice.
module pipe_stage_reg #(
  parameter int unsigned LANES       = 2,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned DEPTH       = 1,
  parameter bit          ZERO_BUBBLE = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input logic             clk,
  input logic             rst,
  pipe_stage_reg_if.slave bus
);

  localparam int unsigned CountW = $clog2(LANES + 1);

  if (DEPTH < 1 || LANES < 1 || CNT_W < 1) begin : gen_param_check
    $fatal(1, "pipe_stage_reg: DEPTH, LANES and CNT_W must all be >= 1");
  end

  logic [LANES-1:0]        valid_q [DEPTH];
  logic [LANES-1:0]        valid_d [DEPTH];
  logic [LANES*DATA_W-1:0] data_q  [DEPTH];
  logic [LANES*DATA_W-1:0] data_d  [DEPTH];
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;
  logic [CountW-1:0]       count_w;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_d[k] = '0;
        if (ZERO_BUBBLE) data_d[k] = '0;
      end
    end else if (!bus.stall_next) begin
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        data_d[k]  = data_q[k-1];
      end
      if (bus.stall_prev) begin
        // Bubble: kill_mask and in_* are ignored; payload of slice 0 only matters if zeroing.
        valid_d[0] = '0;
        if (ZERO_BUBBLE) data_d[0] = '0;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      end else begin
        valid_d[0] = bus.in_valid & ~bus.kill_mask;
        data_d[0]  = bus.in_data;
        for (int l = 0; l < LANES; l++) begin
          if (ZERO_BUBBLE && !valid_d[0][l]) data_d[0][l*DATA_W +: DATA_W] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= '0;
        data_q[k]  <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= valid_d[k];
        data_q[k]  <= data_d[k];
      end
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    count_w = '0;
    for (int l = 0; l < LANES; l++) count_w += CountW'(valid_q[DEPTH-1][l]);
  end

  assign bus.out_valid  = valid_q[DEPTH-1];
  assign bus.out_data   = data_q[DEPTH-1];
  assign bus.out_count  = count_w;
  assign bus.bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives four pipe_stage_reg configurations with one directed sequence and checks each against
// a queue-based model every cycle, plus literal expectations at key points.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [1:0]  v;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  in_valid = 2'b11;
  logic [31:0] in_data = '0;
  logic [1:0]  kill_mask = '0;
  logic        stall_prev = 1'b0;
  logic        stall_next = 1'b0;
  logic        flush = 1'b0;
  bit          chk_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // Instance configs: a=D1/zero, b=D1/no-zero, c=D3/zero, d=D1/zero/2-bit counter.
  int unsigned dep  [4] = '{1, 1, 3, 1};
  bit          zb   [4] = '{1, 0, 1, 1};
  int unsigned cmax [4] = '{65535, 65535, 65535, 3};
  ent_t        pq   [4][$];
  int unsigned mcnt [4];

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.LANES(2), .DATA_W(16), .CNT_W(16)) if_a ();
  pipe_stage_reg_if #(.LANES(2), .DATA_W(16), .CNT_W(16)) if_b ();
  pipe_stage_reg_if #(.LANES(2), .DATA_W(16), .CNT_W(16)) if_c ();
  pipe_stage_reg_if #(.LANES(2), .DATA_W(16), .CNT_W(2))  if_d ();

  assign {if_a.in_valid, if_b.in_valid, if_c.in_valid, if_d.in_valid}         = {4{in_valid}};
  assign {if_a.in_data, if_b.in_data, if_c.in_data, if_d.in_data}             = {4{in_data}};
  assign {if_a.kill_mask, if_b.kill_mask, if_c.kill_mask, if_d.kill_mask}     = {4{kill_mask}};
  assign {if_a.stall_prev, if_b.stall_prev, if_c.stall_prev, if_d.stall_prev} = {4{stall_prev}};
  assign {if_a.stall_next, if_b.stall_next, if_c.stall_next, if_d.stall_next} = {4{stall_next}};
  assign {if_a.flush, if_b.flush, if_c.flush, if_d.flush}                     = {4{flush}};

  pipe_stage_reg #(.LANES(2), .DATA_W(16), .DEPTH(1), .ZERO_BUBBLE(1'b1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .bus(if_a));
  pipe_stage_reg #(.LANES(2), .DATA_W(16), .DEPTH(1), .ZERO_BUBBLE(1'b0), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .bus(if_b));
  pipe_stage_reg #(.LANES(2), .DATA_W(16), .DEPTH(3), .ZERO_BUBBLE(1'b1), .CNT_W(16)) u_c (
    .clk(clk), .rst(rst), .bus(if_c));
  pipe_stage_reg #(.LANES(2), .DATA_W(16), .DEPTH(1), .ZERO_BUBBLE(1'b1), .CNT_W(2)) u_d (
    .clk(clk), .rst(rst), .bus(if_d));

  logic [1:0]  ov [4];
  logic [31:0] od [4];
  logic [1:0]  oc [4];
  logic [15:0] ob [4];
  assign ov = '{if_a.out_valid, if_b.out_valid, if_c.out_valid, if_d.out_valid};
  assign od = '{if_a.out_data, if_b.out_data, if_c.out_data, if_d.out_data};
  assign oc = '{if_a.out_count, if_b.out_count, if_c.out_count, if_d.out_count};
  assign ob = '{if_a.bubble_cnt, if_b.bubble_cnt, if_c.bubble_cnt, {14'b0, if_d.bubble_cnt}};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  // Model: each config is a list of entries, newest at the front, output at the back.
  task automatic model_edge();
    ent_t e;
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        pq[i].delete();
        for (int k = 0; k < int'(dep[i]); k++) pq[i].push_back('0);
        mcnt[i] = 0;
      end else if (flush) begin
        for (int k = 0; k < pq[i].size(); k++) begin
          e = pq[i][k];
          e.v = '0;
          if (zb[i]) e.d = '0;
          pq[i][k] = e;
        end
      end else if (!stall_next) begin
        if (stall_prev) begin
          e = '0;
          if (mcnt[i] < cmax[i]) mcnt[i]++;
        end else begin
          e.v = in_valid & ~kill_mask;
          e.d = in_data;
          for (int l = 0; l < 2; l++) if (!e.v[l]) e.d[l*16 +: 16] = '0;
        end
        pq[i].push_front(e);
        void'(pq[i].pop_back());
      end
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int j = 0; j < n; j++) begin
      model_edge();
      @(negedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        ent_t t;
        logic [31:0] m;
        t = pq[i][pq[i].size()-1];
        m = zb[i] ? 32'hFFFF_FFFF : {{16{t.v[1]}}, {16{t.v[0]}}};
        check($sformatf("out_valid[%0d]", i), 64'(ov[i]), 64'(t.v));
        check($sformatf("out_data[%0d]", i), 64'(od[i] & m), 64'(t.d & m));
        check($sformatf("out_count[%0d]", i), 64'(oc[i]), 64'($countones(t.v)));
        check($sformatf("bubble_cnt[%0d]", i), 64'(ob[i]), 64'(mcnt[i]));
      end
    end
  end

  initial begin
    @(negedge clk);
    #1;
    cyc();
    chk_en = 1'b1;
    check("reset out_valid", 64'(if_a.out_valid), 64'h0);
    check("reset out_data", 64'(if_a.out_data), 64'h0);
    check("reset bubble_cnt", 64'(if_a.bubble_cnt), 64'h0);
    rst = 1'b0;

    in_data = 32'hAAAA_BBBB;
    cyc();
    check("advance out_valid", 64'(if_a.out_valid), 64'h3);
    check("advance out_data", 64'(if_a.out_data), 64'hAAAA_BBBB);
    check("advance out_count", 64'(if_a.out_count), 64'h2);
    check("depth3 not yet out", 64'(if_c.out_valid), 64'h0);

    stall_prev = 1'b1;
    cyc(3);
    check("bubble out_valid", 64'(if_a.out_valid), 64'h0);
    check("bubble out_data", 64'(if_a.out_data), 64'h0);
    check("bubble cnt", 64'(if_a.bubble_cnt), 64'h3);

    stall_prev = 1'b0;
    in_data = 32'h1234_5678;
    cyc();
    stall_prev = 1'b1;
    stall_next = 1'b1;
    in_data = 32'hFFFF_FFFF;
    cyc(3);
    check("hold out_data", 64'(if_a.out_data), 64'h1234_5678);
    check("hold bubble_cnt", 64'(if_a.bubble_cnt), 64'h3);

    stall_prev = 1'b0;
    stall_next = 1'b0;
    kill_mask = 2'b10;
    in_data = 32'hDEAD_BEEF;
    cyc();
    check("kill out_valid", 64'(if_a.out_valid), 64'h1);
    check("kill out_data", 64'(if_a.out_data), 64'h0000_BEEF);
    check("kill out_count", 64'(if_a.out_count), 64'h1);
    check("kill nozero lane0", 64'(if_b.out_data[15:0]), 64'hBEEF);
    kill_mask = 2'b00;

    in_data = 32'h1111_1111;
    cyc();
    in_data = 32'h2222_2222;
    cyc();
    in_data = 32'h3333_3333;
    cyc();
    check("depth3 X out", 64'(if_c.out_data), 64'h1111_1111);
    stall_next = 1'b1;
    in_data = 32'h4444_4444;
    cyc(2);
    check("depth3 frozen", 64'(if_c.out_data), 64'h1111_1111);
    flush = 1'b1;
    stall_prev = 1'b1;
    cyc();
    check("flush out_valid", 64'(if_c.out_valid), 64'h0);
    check("flush out_data", 64'(if_c.out_data), 64'h0);
    check("flush keeps cnt", 64'(if_a.bubble_cnt), 64'h3);
    flush = 1'b0;
    stall_prev = 1'b0;
    stall_next = 1'b0;
    in_valid = 2'b00;
    cyc(2);
    check("depth3 drained", 64'(if_c.out_valid), 64'h0);

    stall_prev = 1'b1;
    cyc(5);
    check("sat cnt", 64'(if_d.bubble_cnt), 64'h3);
    check("wide cnt", 64'(if_a.bubble_cnt), 64'h8);
    rst = 1'b1;
    cyc();
    check("rst cnt", 64'(if_d.bubble_cnt), 64'h0);
    rst = 1'b0;
    cyc(5);
    check("sat cnt again", 64'(if_d.bubble_cnt), 64'h3);
    check("wide cnt again", 64'(if_a.bubble_cnt), 64'h5);
    stall_prev = 1'b0;
    in_valid = 2'b01;
    in_data = 32'h5555_6666;
    cyc(3);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
